// File: rtl/diff_rr_scheduler_if.sv
// Handshake bundle for diff_rr_scheduler: multi-channel sample requests in,
// one registered difference result out with valid/ready backpressure.
interface diff_rr_scheduler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]            req_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] req_data;
  logic [NUM_CH-1:0]            req_ready;
  logic [NUM_CH-1:0]            clr_ch;
  logic                         out_valid;
  logic                         out_ready;
  logic [CH_W-1:0]              out_ch;
  logic [DATA_WIDTH-1:0]        out_data;
  logic                         out_ovf;

  // Sources and the downstream consumer together form the master side.
  modport master (
    output req_valid, req_data, clr_ch, out_ready,
    input  req_ready, out_valid, out_ch, out_data, out_ovf
  );

  modport slave (
    input  req_valid, req_data, clr_ch, out_ready,
    output req_ready, out_valid, out_ch, out_data, out_ovf
  );
endinterface

// File: rtl/diff_rr_scheduler.sv
// Round-robin shared first-difference unit: out = x[n] - x[n-1] per channel,
// with a per-channel history bank and a single registered output stage.
module diff_rr_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4
) (
  input logic               clk,
  input logic               rst,
  diff_rr_scheduler_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int DW   = DATA_WIDTH;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  out_state_e       state_q;
  logic [CH_W-1:0]  ptr_q;
  logic [CH_W-1:0]  ptr_d;
  logic [DW-1:0]    hist_q [NUM_CH];
  logic [DW-1:0]    hist_d [NUM_CH];
  logic [CH_W-1:0]  out_ch_q;
  logic [DW-1:0]    out_data_q;
  logic [DW-1:0]    out_data_d;
  logic             out_ovf_q;
  logic             out_ovf_d;

  logic [DW-1:0]     sample_s [NUM_CH];
  logic              can_accept_s;
  logic              gnt_found_s;
  logic [CH_W-1:0]   gnt_idx_s;
  logic [NUM_CH-1:0] grant_s;
  logic              xfer_s;
  logic [DW-1:0]     hist_eff_s;
  logic [DW:0]       diff_s;

  // Channel index base+offs, wrapped modulo NUM_CH (offs < NUM_CH).
  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NUM_CH) begin
      sum = sum - NUM_CH;
    end else begin
      sum = sum;
    end
    return CH_W'(sum);
  endfunction

  // Sign-extended difference one bit wider than the samples, so overflow is visible.
  function automatic logic [DW:0] first_diff(input logic [DW-1:0] x, input logic [DW-1:0] h);
    return {x[DW-1], x} - {h[DW-1], h};
  endfunction

  // Unpack the flat sample bus into per-channel lanes
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sample_s[i] = bus.req_data[i*DW +: DW];
    end
  end

  assign can_accept_s = (state_q == ST_EMPTY) || bus.out_ready;

  // Round-robin search starting at the pointer; grant only while the output can take a result
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    grant_s     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!gnt_found_s && bus.req_valid[wrap_add(ptr_q, k)]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = wrap_add(ptr_q, k);
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
    if (can_accept_s && gnt_found_s) begin
      grant_s[gnt_idx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign xfer_s        = can_accept_s && gnt_found_s;
  assign bus.req_ready = grant_s;

  // Difference datapath; a same-cycle clear makes the history read as zero
  always_comb begin
    if (bus.clr_ch[gnt_idx_s]) begin
      hist_eff_s = '0;
    end else begin
      hist_eff_s = hist_q[gnt_idx_s];
    end
    diff_s     = first_diff(sample_s[gnt_idx_s], hist_eff_s);
    out_data_d = diff_s[DW-1:0];
    out_ovf_d  = diff_s[DW] ^ diff_s[DW-1];
    ptr_d      = wrap_add(gnt_idx_s, 1);
  end

  // History next state: transferred sample wins over a clear of the same channel
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (xfer_s && (gnt_idx_s == CH_W'(i))) begin
        hist_d[i] = sample_s[i];
      end else if (bus.clr_ch[i]) begin
        hist_d[i] = '0;
      end else begin
        hist_d[i] = hist_q[i];
      end
    end
  end

  // History bank registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        hist_q[i] <= hist_d[i];
      end
    end
  end

  // Output stage FSM with result capture and pointer advance on each transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      ptr_q      <= '0;
      out_ch_q   <= '0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (xfer_s) begin
            state_q <= ST_FULL;
          end else begin
            state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (bus.out_ready && !xfer_s) begin
            state_q <= ST_EMPTY;
          end else begin
            state_q <= ST_FULL;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
        end
      endcase
      if (xfer_s) begin
        out_ch_q   <= gnt_idx_s;
        out_data_q <= out_data_d;
        out_ovf_q  <= out_ovf_d;
        ptr_q      <= ptr_d;
      end else begin
        out_ch_q   <= out_ch_q;
        out_data_q <= out_data_q;
        out_ovf_q  <= out_ovf_q;
        ptr_q      <= ptr_q;
      end
    end
  end

  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_ch    = out_ch_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule
